// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types, width helpers and parameter checks for the debounce scanner
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    EVENT = 2'd2
  } scan_state_t;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

  function automatic bit params_ok(input int n_ch, input int tick_div, input int stable_ticks);
    return (n_ch >= 1) && (n_ch <= 32) && (tick_div >= n_ch + 2) && (stable_ticks >= 1);
  endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// rtl/debounce_tick_gen.sv - sample-tick prescaler with pending-tick and sticky overrun flags
module debounce_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic consume_i,
  output logic tick_pend_o,
  output logic overrun_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          tick_pend_q, tick_pend_d;
  logic          overrun_q, overrun_d;

  always_comb begin
    presc_d = '0;
    tick    = 1'b0;
    if (enable_i) begin
      if (presc_q == PRESC_LAST) tick = 1'b1;
      else                       presc_d = presc_q + PW'(1);
    end
    // A tick landing on the cycle the old one is consumed is not lost.
    tick_pend_d = (tick_pend_q & ~consume_i) | tick;
    overrun_d   = overrun_q | (tick & tick_pend_q & ~consume_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q     <= '0;
      tick_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      tick_pend_q <= tick_pend_d;
      overrun_q   <= overrun_d;
    end
  end

  assign tick_pend_o = tick_pend_q;
  assign overrun_o   = overrun_q;

endmodule

// File: rtl/sync.sv
// rtl/sync.sv - multi-bit flop-chain synchronizer for asynchronous level inputs
module sync #(
  parameter int WIDTH       = 1,
  parameter int PIPE_LENGTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [PIPE_LENGTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < PIPE_LENGTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < PIPE_LENGTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[PIPE_LENGTH-1];

endmodule

// File: rtl/debounce_scan_ctrl.sv
// rtl/debounce_scan_ctrl.sv - multi-channel debouncer sharing one stability counter datapath via a channel scan
module debounce_scan_ctrl
  import debounce_pkg::*;
#(
  parameter  int N_CH         = 8,
  parameter  int TICK_DIV     = 1000,
  parameter  int STABLE_TICKS = 16,
  localparam int CH_W         = ch_w(N_CH)
) (
  input  logic            dest_clk_i,
  input  logic            dest_rst_i,
  input  logic [N_CH-1:0] raw_sig_i,
  input  logic            enable_i,
  output logic [N_CH-1:0] db_sig_o,
  output logic            evt_valid_o,
  input  logic            evt_ready_i,
  output logic [CH_W-1:0] evt_ch_o,
  output logic            evt_level_o,
  output logic            busy_o,
  output logic            overrun_o
);

  localparam int CNT_W = cnt_w(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  if (!params_ok(N_CH, TICK_DIV, STABLE_TICKS)) begin : g_param_err
    $error("debounce_scan_ctrl: illegal parameter combination");
  end

  logic [N_CH-1:0]  sync_w;
  logic             tick_pend;
  logic             consume;

  scan_state_t      state_q, state_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [N_CH-1:0]  snap_q;
  logic [N_CH-1:0]  db_q;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CH_W-1:0]  evt_ch_q;
  logic             evt_level_q;

  logic             load_snap, cnt_we, commit, advance;
  logic [CNT_W-1:0] cnt_cur, cnt_nxt;
  logic             snap_bit, db_bit;

  sync #(.WIDTH(N_CH), .PIPE_LENGTH(2)) u_sync (
    .clk_i (dest_clk_i),
    .rst_i (dest_rst_i),
    .d_i   (raw_sig_i),
    .q_o   (sync_w)
  );

  debounce_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk_i       (dest_clk_i),
    .rst_i       (dest_rst_i),
    .enable_i    (enable_i),
    .consume_i   (consume),
    .tick_pend_o (tick_pend),
    .overrun_o   (overrun_o)
  );

  // Single shared compare/increment path, steered by the scan pointer.
  assign snap_bit = snap_q[ptr_q];
  assign db_bit   = db_q[ptr_q];
  assign cnt_cur  = cnt_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    consume   = 1'b0;
    load_snap = 1'b0;
    cnt_we    = 1'b0;
    cnt_nxt   = '0;
    commit    = 1'b0;
    advance   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_pend) begin
          consume   = 1'b1;
          load_snap = 1'b1;
          ptr_d     = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        cnt_we = 1'b1;
        if (snap_bit == db_bit) begin
          cnt_nxt = '0;
        end else if (cnt_cur == CNT_LAST) begin
          commit  = 1'b1;
          state_d = EVENT;
        end else begin
          cnt_nxt = cnt_cur + CNT_W'(1);
        end
        advance = ~commit;
      end
      EVENT:   advance = evt_ready_i;
      default: state_d = IDLE;
    endcase
    if (advance) begin
      if (ptr_q == LAST_CH) begin
        state_d = IDLE;
      end else begin
        ptr_d   = ptr_q + CH_W'(1);
        state_d = SCAN;
      end
    end
  end

  always_ff @(posedge dest_clk_i or posedge dest_rst_i) begin
    if (dest_rst_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge dest_clk_i or posedge dest_rst_i) begin
    if (dest_rst_i) begin
      ptr_q       <= '0;
      snap_q      <= '0;
      db_q        <= '0;
      evt_ch_q    <= '0;
      evt_level_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load_snap) snap_q <= sync_w;
      if (cnt_we)    cnt_q[ptr_q] <= cnt_nxt;
      if (commit) begin
        db_q[ptr_q] <= snap_bit;
        evt_ch_q    <= ptr_q;
        evt_level_q <= snap_bit;
      end
    end
  end

  assign db_sig_o    = db_q;
  assign evt_valid_o = (state_q == EVENT);
  assign evt_ch_o    = evt_ch_q;
  assign evt_level_o = evt_level_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// tb/tb_debounce_scan_ctrl.sv - table-driven and sequence checks for debounce_scan_ctrl
module tb_debounce_scan_ctrl;

  localparam int N_CH = 4;
  localparam int TICK_DIV = 16;
  localparam int STABLE_TICKS = 3;
  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] raw;
  logic            en;
  logic [N_CH-1:0] db;
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_level;
  logic            busy;
  logic            ovr;

  always #5 clk = ~clk;

  debounce_scan_ctrl #(
    .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .dest_clk_i  (clk),
    .dest_rst_i  (rst),
    .raw_sig_i   (raw),
    .enable_i    (en),
    .db_sig_o    (db),
    .evt_valid_o (evt_valid),
    .evt_ready_i (evt_ready),
    .evt_ch_o    (evt_ch),
    .evt_level_o (evt_level),
    .busy_o      (busy),
    .overrun_o   (ovr)
  );

  int n_checks = 0;
  int n_errors = 0;

  int hs_total = 0;
  int valid_total = 0;
  int busy_total = 0;
  int last_ch = 0;
  int last_lvl = 0;

  always @(negedge clk) begin
    if (evt_valid) valid_total <= valid_total + 1;
    if (busy) busy_total <= busy_total + 1;
    if (evt_valid && evt_ready) begin
      hs_total <= hs_total + 1;
      last_ch  <= int'(evt_ch);
      last_lvl <= int'(evt_level);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_valid(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk); #1;
      if (evt_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [N_CH-1:0] raw;
    bit              en;
    bit              rdy;
    int              cycles;
    logic [N_CH-1:0] exp_db;
    int              exp_evt;
    int              exp_ch;
    int              exp_lvl;
    bit              chk_busy;
  } seg_t;

  seg_t segs[10];

  initial begin
    int  hs0, v0, b0;
    bit  seen, bad;

    segs[0] = '{4'b0000, 1'b1, 1'b1, 40,  4'b0000, 0, 0, 0, 1'b0};
    segs[1] = '{4'b0100, 1'b1, 1'b1, 64,  4'b0100, 1, 2, 1, 1'b0};
    segs[2] = '{4'b0110, 1'b1, 1'b1, 20,  4'b0100, 0, 0, 0, 1'b0};
    segs[3] = '{4'b0100, 1'b1, 1'b1, 64,  4'b0100, 0, 0, 0, 1'b0};
    segs[4] = '{4'b0000, 1'b1, 1'b1, 64,  4'b0000, 1, 2, 0, 1'b0};
    segs[5] = '{4'b0000, 1'b0, 1'b1, 10,  4'b0000, 0, 0, 0, 1'b0};
    segs[6] = '{4'b0001, 1'b0, 1'b1, 100, 4'b0000, 0, 0, 0, 1'b1};
    segs[7] = '{4'b0001, 1'b1, 1'b1, 40,  4'b0000, 0, 0, 0, 1'b0};
    segs[8] = '{4'b0001, 1'b1, 1'b1, 24,  4'b0001, 1, 0, 1, 1'b0};
    segs[9] = '{4'b0000, 1'b1, 1'b1, 64,  4'b0000, 1, 0, 0, 1'b0};

    rst = 1'b1;
    raw = N_CH'($urandom_range(0, 15));
    en = 1'b1;
    evt_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("reset_outs_c%0d", c), 32'({db, evt_valid, evt_ch, evt_level, busy, ovr}), 32'd0);
      raw = N_CH'($urandom_range(0, 15));
    end
    rst = 1'b0;
    raw = '0;

    for (int i = 0; i < 10; i++) begin
      raw = segs[i].raw;
      en = segs[i].en;
      evt_ready = segs[i].rdy;
      hs0 = hs_total;
      v0 = valid_total;
      b0 = busy_total;
      repeat (segs[i].cycles) @(posedge clk);
      #1;
      chk($sformatf("seg%0d_db", i), 32'(db), 32'(segs[i].exp_db));
      chk($sformatf("seg%0d_events", i), 32'(hs_total - hs0), 32'(segs[i].exp_evt));
      chk($sformatf("seg%0d_valid_cycles", i), 32'(valid_total - v0), 32'(segs[i].exp_evt));
      chk($sformatf("seg%0d_overrun", i), 32'(ovr), 32'd0);
      if (segs[i].exp_evt > 0) begin
        chk($sformatf("seg%0d_evt_ch", i), 32'(last_ch), 32'(segs[i].exp_ch));
        chk($sformatf("seg%0d_evt_level", i), 32'(last_lvl), 32'(segs[i].exp_lvl));
      end
      if (segs[i].chk_busy) chk($sformatf("seg%0d_busy_cycles", i), 32'(busy_total - b0), 32'd0);
    end

    // Back-pressure: ch0 and ch3 rise together, consumer stalls 40 cycles.
    raw = 4'b1001;
    evt_ready = 1'b0;
    wait_valid(100, seen);
    chk("bp_first_valid_seen", 32'(seen), 32'd1);
    chk("bp_first_ch", 32'(evt_ch), 32'd0);
    chk("bp_first_level", 32'(evt_level), 32'd1);
    chk("bp_first_db", 32'(db), 32'b0001);
    chk("bp_overrun_before_stall", 32'(ovr), 32'd0);
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (!evt_valid || evt_ch != 2'd0 || !evt_level) bad = 1'b1;
    end
    chk("bp_event_held_stable", 32'(bad), 32'd0);
    chk("bp_overrun_set", 32'(ovr), 32'd1);
    evt_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_drops_after_accept", 32'(evt_valid), 32'd0);
    wait_valid(20, seen);
    chk("bp_second_valid_seen", 32'(seen), 32'd1);
    chk("bp_second_ch", 32'(evt_ch), 32'd3);
    chk("bp_second_level", 32'(evt_level), 32'd1);
    chk("bp_second_db", 32'(db), 32'b1001);
    @(posedge clk); #1;
    chk("bp_second_single_cycle", 32'(evt_valid), 32'd0);
    chk("bp_overrun_sticky", 32'(ovr), 32'd1);

    // Asynchronous reset while an event is being offered.
    repeat (20) @(posedge clk);
    #1;
    raw = 4'b0000;
    evt_ready = 1'b0;
    wait_valid(100, seen);
    chk("ar_valid_seen", 32'(seen), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("ar_valid_low", 32'(evt_valid), 32'd0);
    chk("ar_busy_low", 32'(busy), 32'd0);
    chk("ar_db_zero", 32'(db), 32'd0);
    chk("ar_overrun_cleared", 32'(ovr), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    evt_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_outs", 32'({db, evt_valid, busy, ovr}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
